// File: rtl/mux_tree_pipelined.sv
// Pipelined N-to-1 word multiplexer with a valid/ready handshake.
// The select tree is cut into register stages every LEVELS_PER_STAGE levels.
module mux_tree_pipelined #(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned N                = 32,
    parameter int unsigned LEVELS_PER_STAGE = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [$clog2(N)-1:0]   sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
);

    localparam int unsigned SEL_W = $clog2(N);
    localparam int unsigned L     = SEL_W;
    localparam int unsigned LP    = LEVELS_PER_STAGE;
    localparam int unsigned S     = (L + LP - 1) / LP;

    // Tree levels resolved once stage k has been passed.
    function automatic int unsigned lv_end(input int unsigned k);
        return ((k + 1) * LP < L) ? (k + 1) * LP : L;
    endfunction

    function automatic int unsigned words_out(input int unsigned k);
        return (N + (32'd1 << lv_end(k)) - 1) >> lv_end(k);
    endfunction

    function automatic int unsigned words_in(input int unsigned k);
        if (k == 0) return N;
        return words_out(k - 1);
    endfunction

    // Bit offsets of each stage's slice within the flat data / sel registers.
    function automatic int unsigned doff(input int unsigned k);
        int unsigned acc;
        acc = 0;
        for (int unsigned i = 0; i < k; i++) acc += words_out(i) * WIDTH;
        return acc;
    endfunction

    function automatic int unsigned soff(input int unsigned k);
        int unsigned acc;
        acc = 0;
        for (int unsigned i = 0; i < k; i++) acc += L - lv_end(i);
        return acc;
    endfunction

    localparam int unsigned DATA_TOT  = doff(S);
    localparam int unsigned SEL_TOT   = soff(S);
    localparam int unsigned SEL_TOT_P = (SEL_TOT == 0) ? 1 : SEL_TOT;

    logic [DATA_TOT-1:0]  data_q;
    wire  [DATA_TOT-1:0]  data_nxt;
    wire  [DATA_TOT-1:0]  data_ld;
    logic [SEL_TOT_P-1:0] sel_q;
    wire  [SEL_TOT_P-1:0] sel_nxt;
    wire  [SEL_TOT_P-1:0] sel_ld;
    logic [S-1:0]         v_q;
    logic [S-1:0]         v_in;
    logic [S-1:0]         rdy;

    // Ready chain from the output back to the input; lets bubbles collapse.
    always_comb begin
        logic acc;
        rdy  = '0;
        v_in = '0;
        acc  = out_ready;
        for (int k = int'(S) - 1; k >= 0; k--) begin
            acc    = !v_q[k] || acc;
            rdy[k] = acc;
        end
        v_in[0] = in_valid;
        for (int k = 1; k < int'(S); k++) v_in[k] = v_q[k-1];
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int unsigned LV0  = k * LP;
        localparam int unsigned NL   = lv_end(k) - LV0;
        localparam int unsigned WI   = words_in(k);
        localparam int unsigned WO   = words_out(k);
        localparam int unsigned SIN  = L - LV0;
        localparam int unsigned SOUT = SIN - NL;
        localparam int unsigned PW   = (WO << NL) * WIDTH;

        logic [WI*WIDTH-1:0] d_in;
        logic [SIN-1:0]      s_in;
        logic [PW-1:0]       d_pad;
        logic [WO*WIDTH-1:0] d_red;

        if (k == 0) begin : g_src
            assign d_in = in_data;
            assign s_in = sel;
        end else begin : g_src
            assign d_in = data_q[doff(k-1) +: WI*WIDTH];
            assign s_in = sel_q[soff(k-1) +: SIN];
        end

        // Leaves past the last real word are zero, so out-of-range selects yield 0.
        always_comb begin
            int idx;
            d_pad = PW'(d_in);
            d_red = '0;
            for (int o = 0; o < int'(WO); o++) begin
                idx = ((o << NL) + int'(s_in[NL-1:0])) * int'(WIDTH);
                d_red[o*WIDTH +: WIDTH] = d_pad[idx +: WIDTH];
            end
        end

        assign data_nxt[doff(k) +: WO*WIDTH] = d_red;
        assign data_ld[doff(k) +: WO*WIDTH]  = {(WO*WIDTH){rdy[k]}};

        if (SOUT > 0) begin : g_sel
            assign sel_nxt[soff(k) +: SOUT] = s_in[SIN-1:NL];
            assign sel_ld[soff(k) +: SOUT]  = {SOUT{rdy[k]}};
        end
    end

    if (SEL_TOT == 0) begin : g_nosel
        assign sel_nxt = '0;
        assign sel_ld  = '0;
    end

    // Stage registers: a stage loads when its ready is high, otherwise holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q    <= '0;
            data_q <= '0;
            sel_q  <= '0;
        end else begin
            v_q    <= flush ? '0 : ((v_in & rdy) | (v_q & ~rdy));
            data_q <= (data_nxt & data_ld) | (data_q & ~data_ld);
            sel_q  <= (sel_nxt & sel_ld) | (sel_q & ~sel_ld);
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[S-1];
    assign out_data  = data_q[doff(S-1) +: WIDTH];

endmodule

// File: tb/tb_mux_tree_pipelined.sv
// Directed bench for mux_tree_pipelined: default 32x8 instance and a 5x4 one-level-per-stage instance.
module tb_mux_tree_pipelined;

    logic clk;
    logic reset_n;

    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [255:0] a_in_data;
    logic [4:0]   a_sel;
    logic [7:0]   a_out_data;

    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [19:0]  b_in_data;
    logic [2:0]   b_sel;
    logic [3:0]   b_out_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] oor_sel [4] = '{3'd4, 3'd5, 3'd7, 3'd0};
    logic [3:0] oor_exp [4] = '{4'h5, 4'h0, 4'h0, 4'h1};
    logic [7:0] iso_exp [6];

    mux_tree_pipelined #(.WIDTH(8), .N(32), .LEVELS_PER_STAGE(2)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .sel(a_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    mux_tree_pipelined #(.WIDTH(4), .N(5), .LEVELS_PER_STAGE(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .sel(b_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sweep_data();
        for (int i = 0; i < 32; i++) a_in_data[i*8 +: 8] = 8'(32'h40 + i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        reset_n = 1'b1;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_sel = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_sel = '0;
        load_sweep_data();
        for (int i = 0; i < 5; i++) b_in_data[i*4 +: 4] = 4'(i + 1);

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check("rst out_valid", 32'(a_out_valid), 32'd0);
        check("rst out_data", 32'(a_out_data), 32'd0);
        check("rst in_ready", 32'(a_in_ready), 32'd1);
        check("rst b out_valid", 32'(b_out_valid), 32'd0);
        step();
        step();
        reset_n = 1'b1;

        // Sweep sel 0..31 at full throughput
        a_out_ready = 1;
        for (int e = 0; e < 35; e++) begin
            a_in_valid = (e < 32);
            a_sel = 5'(e);
            step();
            if (e >= 2 && e < 34) begin
                check("sweep valid", 32'(a_out_valid), 32'd1);
                check("sweep data", 32'(a_out_data), 32'(32'h40 + e - 2));
            end else begin
                check("sweep idle", 32'(a_out_valid), 32'd0);
            end
        end
        a_in_valid = 0;

        // Backpressure
        a_out_ready = 0;
        a_in_valid = 1;
        a_sel = 5'd5; step();
        check("bp ready 1", 32'(a_in_ready), 32'd1);
        a_sel = 5'd6; step();
        check("bp ready 2", 32'(a_in_ready), 32'd1);
        a_sel = 5'd7; step();
        check("bp ready full", 32'(a_in_ready), 32'd0);
        check("bp valid", 32'(a_out_valid), 32'd1);
        check("bp data", 32'(a_out_data), 32'h45);
        a_sel = 5'd8;
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp hold ready", 32'(a_in_ready), 32'd0);
            check("bp hold valid", 32'(a_out_valid), 32'd1);
            check("bp hold data", 32'(a_out_data), 32'h45);
        end
        a_out_ready = 1;
        #1;
        check("bp ready release", 32'(a_in_ready), 32'd1);
        step();
        a_in_valid = 0;
        check("bp out 46", 32'(a_out_data), 32'h46);
        check("bp valid 46", 32'(a_out_valid), 32'd1);
        step();
        check("bp out 47", 32'(a_out_data), 32'h47);
        step();
        check("bp out 48", 32'(a_out_data), 32'h48);
        check("bp valid 48", 32'(a_out_valid), 32'd1);
        step();
        check("bp drained", 32'(a_out_valid), 32'd0);

        // Out-of-range selects on N=5
        b_out_ready = 1;
        for (int e = 0; e < 6; e++) begin
            b_in_valid = (e < 4);
            if (e < 4) b_sel = oor_sel[e];
            step();
            if (e >= 2) begin
                check("oor valid", 32'(b_out_valid), 32'd1);
                check("oor data", 32'(b_out_data), 32'(oor_exp[e-2]));
            end
        end
        b_in_valid = 0;

        // Input isolation: data and sel change every cycle
        a_out_ready = 1;
        for (int e = 0; e < 8; e++) begin
            for (int i = 0; i < 32; i++) a_in_data[i*8 +: 8] = 8'(i * 7 + e * 13 + 1);
            a_sel = 5'((e * 11 + 3) % 32);
            a_in_valid = (e < 6);
            if (e < 6) iso_exp[e] = 8'(((e * 11 + 3) % 32) * 7 + e * 13 + 1);
            step();
            if (e >= 2) begin
                check("iso valid", 32'(a_out_valid), 32'd1);
                check("iso data", 32'(a_out_data), 32'(iso_exp[e-2]));
            end
        end
        a_in_valid = 0;
        load_sweep_data();
        step();
        check("iso drained", 32'(a_out_valid), 32'd0);

        // Flush with three in flight and a concurrent request
        a_in_valid = 1;
        a_sel = 5'd1; step();
        a_sel = 5'd2; step();
        a_sel = 5'd3; step();
        check("fl pre valid", 32'(a_out_valid), 32'd1);
        check("fl pre data", 32'(a_out_data), 32'h41);
        a_flush = 1; a_sel = 5'd9;
        step();
        check("fl cleared", 32'(a_out_valid), 32'd0);
        a_flush = 0; a_sel = 5'd10;
        step();
        a_in_valid = 0;
        check("fl no stale 1", 32'(a_out_valid), 32'd0);
        step();
        check("fl no stale 2", 32'(a_out_valid), 32'd0);
        step();
        check("fl new valid", 32'(a_out_valid), 32'd1);
        check("fl new data", 32'(a_out_data), 32'h4a);
        step();
        check("fl drained", 32'(a_out_valid), 32'd0);

        // Asynchronous reset mid-stream
        a_out_ready = 0;
        a_in_valid = 1;
        a_sel = 5'd20; step();
        a_sel = 5'd21; step();
        a_sel = 5'd22; step();
        a_in_valid = 0;
        check("mr pre valid", 32'(a_out_valid), 32'd1);
        check("mr pre data", 32'(a_out_data), 32'h54);
        #2 reset_n = 1'b0;
        #1;
        check("mr async valid", 32'(a_out_valid), 32'd0);
        check("mr async data", 32'(a_out_data), 32'd0);
        check("mr async ready", 32'(a_in_ready), 32'd1);
        step();
        step();
        reset_n = 1'b1;
        a_out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("mr no stale", 32'(a_out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_tree_pipelined.md
# mux_tree_pipelined

Parametrised, pipelined N-to-1 multiplexer for WIDTH-bit words, with a valid/ready handshake and full backpressure. The select tree is split into register stages every LEVELS_PER_STAGE levels, so wide selects (register-file read ports, forwarding and writeback select) close timing at CPU clock rates. Each accepted request carries its inputs and select through the pipeline together, so in-flight transactions are independent of later changes on in_data and sel.

## Interface
- WIDTH, 32: bits per input word; must be 1 or more.
- N, 32: number of input words; must be 2 or more; need not be a power of two.
- LEVELS_PER_STAGE, 2: 2:1 tree levels per pipeline stage; must be 1 or more.
- Derived: SEL_W = $clog2(N); L = SEL_W tree levels; S = ceil(L / LEVELS_PER_STAGE) pipeline stages.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all in-flight transactions.
- in_valid  in  1  request present.
- in_ready  out  1  pipeline can accept a request this cycle.
- in_data  in  N*WIDTH  word i is in_data[i*WIDTH +: WIDTH].
- sel  in  SEL_W  index of the selected word.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  selected word.

## Operation
- Stage k (k = 0..S-1) resolves tree levels k·LP .. min((k+1)·LP, L)-1, where LP = LEVELS_PER_STAGE. Level j consumes sel bit j, LSB first, so stage 0 uses sel[LP-1:0].
- Each stage registers:
  - its reduced partial words (N/2^levels, rounded up);
  - the sel bits not yet consumed;
  - a valid bit v_k.
- If sel is N or greater, out_data is all zeros. Tree leaves at indices N or greater are tied to zero, which gives this result.
- Ready chain:
  - r_S = out_ready.
  - r_k = !v_k || r_(k+1).
  - in_ready = r_0.
  - This is combinational and allows bubble collapse.
- Stage k loads from its predecessor when r_k is 1.
  - v_k becomes the predecessor's valid, or in_valid for k = 0.
  - When r_k is 0, stage k holds its contents.
- out_valid = v_(S-1). out_data comes straight from the last stage register, with no logic after the flop.
- A request transfers when in_valid and in_ready are both 1. A result transfers when out_valid and out_ready are both 1.
- flush clears every v_k on the next edge and drops any in_valid presented in that cycle. Data registers are not cleared.
- Reset (reset_n low, asynchronous):
  - all v_k = 0, so out_valid = 0;
  - all data and sel registers = 0, so out_data = 0.
  - in_ready reads 1 while in reset.
- Reset asserted mid-operation discards all in-flight transactions. No output transfers after the reset edge.

## Timing
- Latency: a request accepted at edge t shows out_valid = 1 after edge t+S-1, i.e. S edges after the cycle in which it was presented.
  - Defaults: L = 5, S = 3.
- Throughput: one transaction per cycle while out_ready is 1.
- Stall:
  - While out_valid = 1 and out_ready = 0, out_data and out_valid are held stable.
  - Upstream stages keep filling any bubbles.
  - in_ready falls only when every stage is valid.
- Simultaneous stall and input:
  - All stages full, with out_ready and in_valid both 1 in the same cycle: the pipeline shifts and accepts, with no bubble.
- Flush versus reset: flush has lower priority than reset. Flush and transfer in the same cycle: flush wins and no new valid is loaded. The result on out_data that cycle is still considered transferred if out_ready = 1.
- Edge case: if L = 0 cannot occur (N is 2 or more), then S is 1 or more.

## Test plan
- Reset:
  - Stimulus: assert reset_n = 0 mid-stream, with 3 transactions in flight and defaults WIDTH=8, N=32.
  - Required: out_valid = 0 and out_data = 0 immediately, without waiting for a clock edge.
  - After release, no stale result appears.
- Sweep, defaults with WIDTH=8:
  - Stimulus: in_data word i = i+0x40; apply sel = 0..31 on consecutive cycles with out_ready = 1.
  - Required: out_valid rises 3 edges after the first accept. Outputs are 0x40..0x5F, in order, one per cycle.
- Backpressure:
  - Stimulus: stream sel = 5, 6, 7, 8 and hold out_ready = 0 for 4 cycles.
  - Required: out_data holds 0x45; in_ready falls after the 3rd accept. After out_ready returns to 1, outputs 0x46, 0x47, 0x48 follow with no loss or duplication.
- Out of range:
  - Stimulus: N=5, WIDTH=4, LEVELS_PER_STAGE=1 (S = 3); words 1..5; sel = 4, then 5, then 7.
  - Required: outputs 0x5, 0x0, 0x0.
- Input isolation:
  - Stimulus: change in_data and sel every cycle after an accept.
  - Required: each result equals the word selected at that transaction's own accept cycle.
- Flush:
  - Stimulus: 3 in flight; assert flush together with in_valid = 1.
  - Required: out_valid = 0 on the next cycle and no result from those transactions ever appears. A request presented the cycle after flush emerges with normal latency.
